// File: rtl/ysyx_24080014_pkg.sv
// Shared constants for the ysyx_24080014 core: operand select codes and
// the operand-stage buffer state encoding.
package ysyx_24080014_pkg;

    localparam logic [2:0] SEL_PC     = 3'b000;
    localparam logic [2:0] SEL_PC_ADD = 3'b001;
    localparam logic [2:0] SEL_RS     = 3'b010;
    localparam logic [2:0] SEL_IMM    = 3'b011;
    localparam logic [2:0] SEL_CSR    = 3'b110;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/ysyx_24080014_opnd_stage_if.sv
// Decode-to-execute operand request/response bundle, including forwarding.
// A transfer happens on a rising edge where valid and ready are both high;
// valid never waits on ready, and an offered payload holds until taken.
interface ysyx_24080014_opnd_stage_if #(
    parameter int XLEN = 32,
    parameter int NFWD = 2
);
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [XLEN-1:0]        in_pc;
    logic [XLEN-1:0]        in_imm;
    logic [XLEN-1:0]        in_csr_data;
    logic [4:0]             in_rs1_idx;
    logic [4:0]             in_rs2_idx;
    logic [XLEN-1:0]        in_rs1_data;
    logic [XLEN-1:0]        in_rs2_data;
    logic [2:0]             in_rs1_ctr;
    logic [2:0]             in_rs2_ctr;
    logic [NFWD-1:0]        fwd_valid;
    logic [NFWD-1:0]        fwd_pend;
    logic [5*NFWD-1:0]      fwd_rd;
    logic [XLEN*NFWD-1:0]   fwd_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [XLEN-1:0]        out_rs1;
    logic [XLEN-1:0]        out_rs2;
    logic [XLEN-1:0]        out_pc;

    modport master (
        output flush, in_valid, in_pc, in_imm, in_csr_data, in_rs1_idx, in_rs2_idx,
               in_rs1_data, in_rs2_data, in_rs1_ctr, in_rs2_ctr,
               fwd_valid, fwd_pend, fwd_rd, fwd_data, out_ready,
        input  in_ready, out_valid, out_rs1, out_rs2, out_pc
    );

    modport slave (
        input  flush, in_valid, in_pc, in_imm, in_csr_data, in_rs1_idx, in_rs2_idx,
               in_rs1_data, in_rs2_data, in_rs1_ctr, in_rs2_ctr,
               fwd_valid, fwd_pend, fwd_rd, fwd_data, out_ready,
        output in_ready, out_valid, out_rs1, out_rs2, out_pc
    );

endinterface

// File: rtl/ysyx_24080014_opnd_mux.sv
// Combinational operand select for one ALU operand, with GPR forwarding
// from later stages; pend flags a youngest matching source still in flight.
module ysyx_24080014_opnd_mux
    import ysyx_24080014_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NFWD    = 2,
    parameter int PC_STEP = 4
) (
    input  logic [2:0]           ctr,
    input  logic [4:0]           idx,
    input  logic [XLEN-1:0]      pc,
    input  logic [XLEN-1:0]      imm,
    input  logic [XLEN-1:0]      csr_data,
    input  logic [XLEN-1:0]      rs_data,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD-1:0]      fwd_pend,
    input  logic [5*NFWD-1:0]    fwd_rd,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    output logic [XLEN-1:0]      value,
    output logic                 pend
);

    logic [XLEN-1:0] gpr;
    logic            gpr_pend;
    logic            found;

    // Only the lowest-index (youngest) match counts; older ones are shadowed
    // even when the youngest one is still pending.
    always_comb begin
        gpr      = rs_data;
        gpr_pend = 1'b0;
        found    = 1'b0;
        if (idx == 5'd0) begin
            gpr = '0;
        end else begin
            for (int k = 0; k < NFWD; k++) begin
                if (!found && fwd_valid[k] && (fwd_rd[5*k +: 5] == idx)) begin
                    found = 1'b1;
                    if (fwd_pend[k]) gpr_pend = 1'b1;
                    else             gpr      = fwd_data[XLEN*k +: XLEN];
                end
            end
        end
    end

    always_comb begin
        value = '0;
        pend  = 1'b0;
        case (ctr)
            SEL_PC:     value = pc;
            SEL_PC_ADD: value = pc + XLEN'(PC_STEP);
            SEL_RS: begin
                value = gpr;
                pend  = gpr_pend;
            end
            SEL_IMM:    value = imm;
            SEL_CSR:    value = csr_data;
            default:    value = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_24080014_opnd_stage.sv
// Registered operand-select stage between decode and execute: two operand
// muxes feeding a 2-entry skid buffer, with load-use interlock and flush.
module ysyx_24080014_opnd_stage
    import ysyx_24080014_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NFWD    = 2,
    parameter int PC_STEP = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    ysyx_24080014_opnd_stage_if.slave        bus,
    output buf_state_e                       state_dbg
);

    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] pc;
    } entry_t;

    buf_state_e      state, state_nxt;
    entry_t          head, tail, new_entry;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            rs1_pend, rs2_pend;
    logic            hazard, push, pop;

    ysyx_24080014_opnd_mux #(.XLEN(XLEN), .NFWD(NFWD), .PC_STEP(PC_STEP)) u_mux_rs1 (
        .ctr       (bus.in_rs1_ctr),
        .idx       (bus.in_rs1_idx),
        .pc        (bus.in_pc),
        .imm       (bus.in_imm),
        .csr_data  (bus.in_csr_data),
        .rs_data   (bus.in_rs1_data),
        .fwd_valid (bus.fwd_valid),
        .fwd_pend  (bus.fwd_pend),
        .fwd_rd    (bus.fwd_rd),
        .fwd_data  (bus.fwd_data),
        .value     (rs1_val),
        .pend      (rs1_pend)
    );

    ysyx_24080014_opnd_mux #(.XLEN(XLEN), .NFWD(NFWD), .PC_STEP(PC_STEP)) u_mux_rs2 (
        .ctr       (bus.in_rs2_ctr),
        .idx       (bus.in_rs2_idx),
        .pc        (bus.in_pc),
        .imm       (bus.in_imm),
        .csr_data  (bus.in_csr_data),
        .rs_data   (bus.in_rs2_data),
        .fwd_valid (bus.fwd_valid),
        .fwd_pend  (bus.fwd_pend),
        .fwd_rd    (bus.fwd_rd),
        .fwd_data  (bus.fwd_data),
        .value     (rs2_val),
        .pend      (rs2_pend)
    );

    assign hazard    = rs1_pend | rs2_pend;
    assign new_entry = '{rs1: rs1_val, rs2: rs2_val, pc: bus.in_pc};
    assign push      = bus.in_valid & bus.in_ready;
    assign pop       = bus.out_valid & bus.out_ready;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BUF_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: if (push) state_nxt = BUF_ONE;
                BUF_ONE: begin
                    if (push && !pop)      state_nxt = BUF_FULL;
                    else if (pop && !push) state_nxt = BUF_EMPTY;
                end
                BUF_FULL:  if (pop) state_nxt = BUF_ONE;
                default:   state_nxt = BUF_EMPTY;
            endcase
        end
    end

    // in_ready deliberately ignores out_ready to keep the timing path short.
    always_comb begin
        bus.out_valid = (state != BUF_EMPTY);
        bus.in_ready  = !bus.flush && !hazard && (state != BUF_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (!bus.flush) begin
            case (state)
                BUF_EMPTY: if (push) head <= new_entry;
                BUF_ONE: begin
                    if (push && pop) head <= new_entry;
                    else if (push)   tail <= new_entry;
                end
                BUF_FULL:  if (pop) head <= tail;
                default: ;
            endcase
        end
    end

    assign bus.out_rs1 = head.rs1;
    assign bus.out_rs2 = head.rs2;
    assign bus.out_pc  = head.pc;

endmodule

// File: tb/tb_ysyx_24080014_opnd_stage.sv
// Directed bench for the operand stage: a vector table for the select and
// forwarding paths, then hand-written interlock, backpressure, flush, reset.
module tb_ysyx_24080014_opnd_stage;
    import ysyx_24080014_pkg::*;

    localparam int XLEN = 32;
    localparam int NFWD = 2;

    typedef struct {
        logic [2:0]  c1;
        logic [2:0]  c2;
        logic [4:0]  i1;
        logic [4:0]  i2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] csr;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [1:0]  fv;
        logic [1:0]  fp;
        logic [9:0]  frd;
        logic [63:0] fdat;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    logic       clk;
    logic       rst_n;
    buf_state_e state_dbg;
    int         checks;
    int         errors;
    vec_t       vecs[10];

    ysyx_24080014_opnd_stage_if #(.XLEN(XLEN), .NFWD(NFWD)) bus ();

    ysyx_24080014_opnd_stage #(.XLEN(XLEN), .NFWD(NFWD), .PC_STEP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.flush       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_pc       = '0;
        bus.in_imm      = '0;
        bus.in_csr_data = '0;
        bus.in_rs1_idx  = '0;
        bus.in_rs2_idx  = '0;
        bus.in_rs1_data = '0;
        bus.in_rs2_data = '0;
        bus.in_rs1_ctr  = SEL_PC;
        bus.in_rs2_ctr  = SEL_PC;
        bus.fwd_valid   = '0;
        bus.fwd_pend    = '0;
        bus.fwd_rd      = '0;
        bus.fwd_data    = '0;
        bus.out_ready   = 1'b1;
    endtask

    task automatic drive_vec(input vec_t v);
        bus.in_valid    = 1'b1;
        bus.in_rs1_ctr  = v.c1;
        bus.in_rs2_ctr  = v.c2;
        bus.in_rs1_idx  = v.i1;
        bus.in_rs2_idx  = v.i2;
        bus.in_pc       = v.pc;
        bus.in_imm      = v.imm;
        bus.in_csr_data = v.csr;
        bus.in_rs1_data = v.d1;
        bus.in_rs2_data = v.d2;
        bus.fwd_valid   = v.fv;
        bus.fwd_pend    = v.fp;
        bus.fwd_rd      = v.frd;
        bus.fwd_data    = v.fdat;
    endtask

    task automatic drive_simple(input logic [31:0] pc, input logic [31:0] imm);
        bus.in_valid   = 1'b1;
        bus.in_rs1_ctr = SEL_PC;
        bus.in_rs2_ctr = SEL_IMM;
        bus.in_pc      = pc;
        bus.in_imm     = imm;
        bus.fwd_valid  = '0;
        bus.fwd_pend   = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //         c1      c2      i1     i2     pc            imm        csr        d1         d2         fv     fp     frd                fdat                           e1            e2
        vecs[0] = '{3'b001, 3'b011, 5'd0, 5'd0, 32'h80000000, 32'h10,   32'h0,    32'h0,    32'h0,    2'b00, 2'b00, 10'h0,            64'h0,                         32'h80000004, 32'h10};
        vecs[1] = '{3'b001, 3'b000, 5'd0, 5'd0, 32'hFFFFFFFC, 32'h0,    32'h0,    32'h0,    32'h0,    2'b00, 2'b00, 10'h0,            64'h0,                         32'h0,        32'hFFFFFFFC};
        vecs[2] = '{3'b101, 3'b110, 5'd0, 5'd0, 32'h100,      32'h0,    32'hC5C5, 32'h0,    32'h0,    2'b00, 2'b00, 10'h0,            64'h0,                         32'h0,        32'hC5C5};
        vecs[3] = '{3'b111, 3'b100, 5'd0, 5'd0, 32'h100,      32'hFF,   32'hFF,   32'hFF,   32'hFF,   2'b00, 2'b00, 10'h0,            64'h0,                         32'h0,        32'h0};
        vecs[4] = '{3'b010, 3'b010, 5'd5, 5'd9, 32'h0,        32'h0,    32'h0,    32'h1111, 32'h2222, 2'b11, 2'b00, {5'd5, 5'd5},     {32'hBBBB, 32'hAAAA},          32'hAAAA,     32'h2222};
        vecs[5] = '{3'b010, 3'b010, 5'd0, 5'd5, 32'h0,        32'h0,    32'h0,    32'hDEAD, 32'h5555, 2'b11, 2'b00, {5'd5, 5'd0},     {32'hBBBB, 32'h77},            32'h0,        32'hBBBB};
        vecs[6] = '{3'b010, 3'b010, 5'd5, 5'd6, 32'h0,        32'h0,    32'h0,    32'h1111, 32'h6666, 2'b10, 2'b00, {5'd5, 5'd5},     {32'hBBBB, 32'hAAAA},          32'hBBBB,     32'h6666};
        vecs[7] = '{3'b010, 3'b010, 5'd3, 5'd3, 32'h0,        32'h0,    32'h0,    32'h1,    32'h2,    2'b11, 2'b10, {5'd3, 5'd3},     {32'hCCCC, 32'h33},            32'h33,       32'h33};
        vecs[8] = '{3'b000, 3'b011, 5'd0, 5'd7, 32'h100,      32'h55,   32'h0,    32'h0,    32'h0,    2'b01, 2'b01, {5'd0, 5'd7},     {32'h0, 32'h9999},             32'h100,      32'h55};
        vecs[9] = '{3'b010, 3'b010, 5'd8, 5'd0, 32'h0,        32'h0,    32'h0,    32'h8888, 32'h0,    2'b00, 2'b00, {5'd8, 5'd8},     {32'h1, 32'h2},                32'h8888,     32'h0};

        drive_idle();
        rst_n = 1'b0;
        #12;
        check("reset_out_valid", 32'(bus.out_valid), 32'h0);
        check("reset_out_rs1",   bus.out_rs1, 32'h0);
        check("reset_out_rs2",   bus.out_rs2, 32'h0);
        check("reset_out_pc",    bus.out_pc,  32'h0);
        check("reset_state",     32'(state_dbg), 32'(BUF_EMPTY));
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven select / forwarding vectors, back to back
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_vec(vecs[i]);
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'h1);
            step();
            check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'h1);
            check($sformatf("vec%0d_rs1", i), bus.out_rs1, vecs[i].e1);
            check($sformatf("vec%0d_rs2", i), bus.out_rs2, vecs[i].e2);
            check($sformatf("vec%0d_pc", i),  bus.out_pc,  vecs[i].pc);
        end
        @(negedge clk);
        drive_idle();
        step();
        check("drain_out_valid", 32'(bus.out_valid), 32'h0);

        // load-use interlock on rs2
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_rs1_ctr = SEL_PC;
        bus.in_rs2_ctr = SEL_RS;
        bus.in_rs2_idx = 5'd7;
        bus.in_rs2_data = 32'hDEAD;
        bus.in_pc      = 32'h200;
        bus.fwd_valid  = 2'b01;
        bus.fwd_pend   = 2'b01;
        bus.fwd_rd     = {5'd0, 5'd7};
        bus.fwd_data   = {32'h0, 32'h0};
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d_in_ready", c), 32'(bus.in_ready), 32'h0);
            step();
            check($sformatf("stall%0d_out_valid", c), 32'(bus.out_valid), 32'h0);
            @(negedge clk);
        end
        bus.fwd_pend = 2'b00;
        bus.fwd_data = {32'h0, 32'h1234};
        #1;
        check("unstall_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        check("unstall_out_valid", 32'(bus.out_valid), 32'h1);
        check("unstall_rs2", bus.out_rs2, 32'h1234);
        @(negedge clk);
        drive_idle();
        step();

        // backpressure: fill to FULL, then drain A then B
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_simple(32'hA0, 32'hA1);
        step();
        @(negedge clk);
        drive_simple(32'hB0, 32'hB1);
        step();
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("full_state",    32'(state_dbg), 32'(BUF_FULL));
        check("full_in_ready", 32'(bus.in_ready), 32'h0);
        check("full_head_pc",  bus.out_pc,  32'hA0);
        check("full_head_rs2", bus.out_rs2, 32'hA1);
        step();
        check("hold_head_pc", bus.out_pc, 32'hA0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        step();
        check("drain_b_valid", 32'(bus.out_valid), 32'h1);
        check("drain_b_pc",    bus.out_pc,  32'hB0);
        check("drain_b_rs2",   bus.out_rs2, 32'hB1);
        step();
        check("drain_empty", 32'(bus.out_valid), 32'h0);

        // flush while FULL with a simultaneous request
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_simple(32'hA0, 32'hA1);
        step();
        @(negedge clk);
        drive_simple(32'hB0, 32'hB1);
        step();
        @(negedge clk);
        drive_simple(32'hC0, 32'hC1);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("flush_in_ready", 32'(bus.in_ready), 32'h0);
        step();
        check("flush_out_valid", 32'(bus.out_valid), 32'h0);
        check("flush_state",     32'(state_dbg), 32'(BUF_EMPTY));
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        step();
        check("flush_dropped", 32'(bus.out_valid), 32'h0);

        // asynchronous reset while ONE
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive_simple(32'hD0, 32'hD1);
        step();
        check("one_valid", 32'(bus.out_valid), 32'h1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(bus.out_valid), 32'h0);
        check("async_out_pc",    bus.out_pc,  32'h0);
        check("async_out_rs1",   bus.out_rs1, 32'h0);
        check("async_out_rs2",   bus.out_rs2, 32'h0);
        check("async_state",     32'(state_dbg), 32'(BUF_EMPTY));
        // release reset mid-cycle with a request still offered
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("rel_no_capture", 32'(bus.out_valid), 32'h0);
        step();
        check("rel_capture_valid", 32'(bus.out_valid), 32'h1);
        check("rel_capture_pc",    bus.out_pc, 32'hD0);

        @(negedge clk);
        drive_idle();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_24080014_opnd_stage.md
# ysyx_24080014_opnd_stage

Registered ALU operand-select stage between decode and execute in the ysyx_24080014 core. It is the pipelined successor of the combinational operand mux:
- parametrised datapath width, PC step and forwarding-port count;
- GPR forwarding from later pipeline stages, with a load-use interlock;
- a 2-entry skid buffer with valid/ready handshakes on both sides;
- synchronous flush for branch and trap redirects.

## Interface
Parameters:
- XLEN, 32, datapath width of operands, PC, immediate and CSR data
- NFWD, 2, number of forwarding sources; index 0 is youngest (EX), highest index oldest (WB)
- PC_STEP, 4, byte increment used for the PC_ADD select

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush, drop all buffered and incoming work
- in_valid  in  1  decode offers an operand request
- in_ready  out  1  stage accepts request this cycle
- in_pc, in_imm, in_csr_data  in  XLEN each  source values
- in_rs1_idx, in_rs2_idx  in  5 each  GPR indices
- in_rs1_data, in_rs2_data  in  XLEN each  register-file read data
- in_rs1_ctr, in_rs2_ctr  in  3 each  select codes
- fwd_valid  in  NFWD  forwarding source holds a writing instruction
- fwd_pend  in  NFWD  that source's result is not yet available (load in flight)
- fwd_rd  in  5*NFWD  destination index per source, packed, source k at [5k+4:5k]
- fwd_data  in  XLEN*NFWD  result per source, packed likewise
- out_valid  out  1  operand pair available
- out_ready  in  1  execute consumes pair
- out_rs1, out_rs2, out_pc  out  XLEN each  selected operands and the instruction PC

## Operation
Select codes:
- 000 PC → in_pc
- 001 PC_ADD → in_pc+PC_STEP, modulo 2^XLEN
- 010 RS_OUT → GPR value
- 011 IMM → in_imm
- 110 CSR_DATA → in_csr_data
- any other code → 0

Forwarding and interlock:
- Forwarding applies only when the code is RS_OUT and the index is nonzero.
- A source matches when the lowest k has fwd_valid[k] and fwd_rd[k] equal to the index.
- On a match with fwd_pend[k]=0, the GPR value is fwd_data[k]; otherwise it is in_rs*_data.
- Index 0 always yields 0, ignoring both the register file and forwarding.
- hazard = either operand has its first match with fwd_pend=1. Older matches are never used when the youngest match is pending.

Buffer:
- States EMPTY, ONE, FULL; out_* present the head entry.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !flush & !hazard & (state!=FULL).
- out_valid = (state!=EMPTY).
- Transitions:
  - EMPTY: push → ONE.
  - ONE: push&!pop → FULL; pop&!push → EMPTY; push&pop → ONE, new entry becomes head.
  - FULL: pop → ONE, tail moves to head; push is impossible.
- flush has highest priority: next state EMPTY, no push, and any pop is ignored.
- Operand values are evaluated at push and stored. Forwarding data arriving after capture is not re-applied; upstream hazard logic guarantees the index/age ordering this relies on.

## Timing
- Latency is 1 cycle: a push at edge N gives out_valid=1 with its data after edge N.
- Throughput is 1 pair/cycle while out_ready=1.
- in_ready depends combinationally on flush, hazard and registered state. It has no path from out_ready.
- out_* are registered. out_valid is stable until popped, and out data holds while out_valid & !out_ready.
- Reset (rst_n=0, any time, asynchronous): state EMPTY, out_valid=0, out_rs1/out_rs2/out_pc=0, both buffer entries cleared.
- Reset deassertion mid-request: the request is not captured before the first clock edge with rst_n=1.
- With flush=1, in_ready=0 in that cycle. out_valid drops on the next edge.

## Structure
- Shared package ysyx_24080014_pkg holds the select-code localparams (SEL_PC, SEL_PC_ADD, SEL_RS, SEL_IMM, SEL_CSR) and the buffer state enum. The old mux migrates to these constants.
- One sub-module, ysyx_24080014_opnd_mux: combinational select plus forwarding for one operand, instantiated twice, outputting value and pending flag.
- The skid buffer stays inline in the top.

## Test plan
- Basic selects: in_pc=0x80000000, in_imm=0x10, codes 001/011, out_ready=1 → one cycle later out_rs1=0x80000004, out_rs2=0x10. PC wrap: in_pc=0xFFFFFFFC with code 001 → 0x00000000. Code 101 → 0.
- Forward priority: rs1_idx=5, fwd0 and fwd1 both rd=5 with data 0xAAAA/0xBBBB, not pending → out_rs1=0xAAAA. rs1_idx=0 with fwd rd=0 → 0.
- Interlock: fwd0 rd=7 pending, rs2_idx=7 code RS → in_ready=0 for 3 cycles. Clearing pend with data 0x1234 → push and out_rs2=0x1234. Same scenario with code IMM → no stall.
- Backpressure: hold out_ready=0 and push A, B → state FULL, in_ready=0, out holds A. Release → A then B on consecutive cycles with no loss or duplication.
- Flush in FULL with a simultaneous in_valid → next cycle out_valid=0 and the incoming request is dropped.
- Async reset: assert rst_n=0 mid-cycle in ONE → out_valid and outputs 0 immediately, no edge required.
